// File: rtl/ysyx_25050147_imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time and returns the word after LATENCY edges.
// Define YSYX_25050147_IMEM_REQCNT_EN to build the accepted-request counter behind req_cnt.
module ysyx_25050147_imem_responder #(
    parameter logic [31:0] BASE       = 32'h80000000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy,
    output logic [31:0]           req_cnt
);

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam int          DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [31:0]             addr_r;
    logic [3:0]              cnt_r;
    logic                    resp_valid_r;
    logic [31:0]             resp_data_r;
    logic                    resp_err_r;
    logic [31:0]             mem_r [DEPTH];
    logic                    req_fire_s;
    logic                    addr_err_s;
    logic [DEPTH_LOG2-1:0]   word_idx_s;

    // 33-bit offset so addresses below BASE or near the top of the space cannot wrap into range.
    function automatic logic fetch_err(input logic [31:0] addr);
        logic [32:0] off;
        off       = {1'b0, addr} - {1'b0, BASE};
        fetch_err = (addr[1:0] != 2'b00) || off[32] || (off >= (33'd4 << DEPTH_LOG2));
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
        word_index = DEPTH_LOG2'((addr - BASE) >> 2);
    endfunction

    assign req_ready  = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign req_fire_s = req_valid && (state_r == ST_IDLE);
    assign addr_err_s = fetch_err(addr_r);
    assign word_idx_s = word_index(addr_r);

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_err   = resp_err_r;

    // Side load port into the instruction array; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Fetch FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'h0;
            cnt_r        <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        addr_r  <= req_addr;
                        cnt_r   <= 4'(LATENCY - 1);
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                        // A load to the same word at this edge is not yet visible here.
                        if (addr_err_s) begin
                            resp_data_r <= EBREAK;
                            resp_err_r  <= 1'b1;
                        end else begin
                            resp_data_r <= mem_r[word_idx_s];
                            resp_err_r  <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    cnt_r        <= 4'd0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_25050147_IMEM_REQCNT_EN
    logic [31:0] req_cnt_r;

    // Counts every accepted request, erroneous ones included; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_cnt_r <= 32'h0;
        end else if (req_fire_s) begin
            req_cnt_r <= req_cnt_r + 32'd1;
        end else begin
            req_cnt_r <= req_cnt_r;
        end
    end

    assign req_cnt = req_cnt_r;
`else
    assign req_cnt = 32'h0;
`endif

endmodule

// File: doc/ysyx_25050147_imem_responder.md
Name: ysyx_25050147_imem_responder

Overview:
- Instruction-memory responder at the fetch end of the core; it serves the core's PC-driven instruction requests.
- Accepts one fetch request at a time over a valid/ready request channel and returns the 32-bit instruction word after a programmable latency over a valid/ready response channel.
- Backed by an internal word array with a side load port used for boot/bench image loading.
- Illegal fetches return the EBREAK encoding plus an error flag, so the core halts cleanly.

Parameters:
- BASE, 32'h80000000, byte address of word 0 (matches the core reset PC).
- DEPTH_LOG2, 12, log2 of array depth in 32-bit words (default 4096 words = 16 KiB).
- LATENCY, 1, edges from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a fetch address.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte fetch address (the core PC).
- resp_valid  out  1  response word available.
- resp_ready  in  1  core accepts the response.
- resp_data  out  32  instruction word.
- resp_err  out  1  fetch was misaligned or out of range.
- load_en  in  1  array write strobe.
- load_addr  in  DEPTH_LOG2  word index to write.
- load_data  in  32  word to write.
- busy  out  1  high whenever the FSM is not IDLE.
- req_cnt  out  32  accepted-request counter (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, resp_valid=0, resp_data=0, resp_err=0, latency counter=0, req_cnt=0. Array contents are not reset.
- Reset asserted mid-transaction abandons the transaction; no response is produced after release.
- FSM states: IDLE, WAIT, RESP.
- req_ready=1 only in IDLE; it is combinational from state only, with no dependence on req_valid.
- IDLE: on req_valid&&req_ready, capture req_addr, load cnt=LATENCY-1, go to WAIT.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, sample the array or error path into resp_data/resp_err, set resp_valid=1, go to RESP.
- Timing: request accepted at edge N gives resp_valid high after edge N+LATENCY.
- RESP: resp_data and resp_err are held stable while resp_valid=1 and resp_ready=0. On resp_valid&&resp_ready at an edge, clear resp_valid and go to IDLE.
- No request is accepted in the same cycle a response completes. Minimum issue interval is LATENCY+2 cycles.
- Error check: resp_err=1 if any of the following holds:
  - req_addr[1:0]!=0;
  - req_addr<BASE;
  - req_addr-BASE >= 4<<DEPTH_LOG2.
- The range check uses 33-bit arithmetic; addresses near 32'hFFFFFFFC must not wrap into range.
- On error: resp_data=32'h00100073 (EBREAK) and the array is not read.
- Word index = (req_addr-BASE)>>2, truncated to DEPTH_LOG2 bits after the range check passes.
- Load port: when load_en=1, write load_data to array[load_addr] at the edge, in any FSM state.
- Simultaneous load and response sampling of the same word at one edge: the response carries the pre-write value.
- busy = (state != IDLE).
- resp_valid, resp_data and resp_err are registered outputs; there are no combinational paths from req_* to resp_*.

Optional Feature:
- Macro: YSYX_25050147_IMEM_REQCNT_EN.
- Defined: req_cnt increments by 1 on each request handshake and wraps from 32'hFFFFFFFF to 0. Erroneous requests are counted.
- Undefined: req_cnt is tied to 32'h0 and no counter register is built.
- All other behaviour is identical in both builds.

Test Plan:
- LATENCY=1: load word 0 = 32'h00000413; request 32'h80000000 accepted at edge N -> resp_valid after edge N+1, resp_data=32'h00000413, resp_err=0, busy=1 until the response handshake.
- LATENCY=3 with resp_ready held low 5 cycles: request 32'h80000004 (array[1]=32'hDEADBEEF) -> resp_valid after edge N+3; data stable through the stall; req_ready=0 throughout; IDLE one edge after resp_ready=1.
- Errors: request 32'h80000002, then 32'h7FFFFFFC, then BASE+16384 (DEPTH_LOG2=12), then 32'hFFFFFFFC -> each returns resp_err=1, resp_data=32'h00100073.
- Load/read collision: array[2]=32'h11111111; request 32'h80000008 with load_en writing 32'h22222222 to index 2 at the sampling edge -> resp_data=32'h11111111. A following request to the same address returns 32'h22222222.
- Reset mid-transaction (LATENCY=4): drive rst low at accept edge +2 -> resp_valid=0, busy=0 immediately; after release no stale response appears and a new request completes normally.
- REQCNT build: issue 3 good and 1 error request -> req_cnt=4. Force the counter to 32'hFFFFFFFF, issue 1 request -> req_cnt=0. In the non-REQCNT build, req_cnt=0 throughout.
